// File: rtl/decode_immediate_sequencer_pkg.sv
// Shared type codes, opcodes and entry layout for the decode front end.
package decode_immediate_sequencer_pkg;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } insn_type_e;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        insn_type_e itype;
        logic       illegal;
    } class_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        insn_type_e  itype;
        logic        illegal;
    } entry_t;

    // Every legal opcode ends in 2'b11, so a non-32-bit encoding falls to default.
    function automatic class_t classify(input logic [6:0] opcode);
        class_t c;
        c = '{itype: R_TYPE, illegal: 1'b0};
        case (opcode)
            OP_LUI, OP_AUIPC:                              c.itype = U_TYPE;
            OP_JAL:                                        c.itype = J_TYPE;
            OP_BRANCH:                                     c.itype = B_TYPE;
            OP_STORE:                                      c.itype = S_TYPE;
            OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM, OP_FENCE: c.itype = I_TYPE;
            OP_OP:                                         c.itype = R_TYPE;
            default:                                       c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_immediate_sequencer_immgen.sv
// Immediate generation for RV32 formats; formats without an immediate yield 0.
module immediate_generator
    import decode_immediate_sequencer_pkg::*;
(
    input  logic [31:7] instruction,
    input  insn_type_e  itype,
    output logic [31:0] immediate
);

    always_comb begin
        immediate = '0;
        case (itype)
            I_TYPE: immediate = {{20{instruction[31]}}, instruction[31:20]};
            S_TYPE: immediate = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            B_TYPE: immediate = {{19{instruction[31]}}, instruction[31], instruction[7],
                                 instruction[30:25], instruction[11:8], 1'b0};
            U_TYPE: immediate = {instruction[31:12], 12'h000};
            J_TYPE: immediate = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                 instruction[20], instruction[30:21], 1'b0};
            default: immediate = '0;
        endcase
    end

endmodule

// File: rtl/decode_immediate_sequencer.sv
// Decode front end: classifying FIFO between fetch and execute with head immediate.
// Optional stall counter enabled by `define DECODE_STALL_COUNTER_EN.
module decode_immediate_sequencer
    import decode_immediate_sequencer_pkg::*;
#(
    parameter int BUFFER_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [2:0]  out_type,
    output logic [31:0] out_immediate,
    output logic        out_illegal
`ifdef DECODE_STALL_COUNTER_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam int PW = $clog2(BUFFER_DEPTH);
    localparam int CW = PW + 1;

    entry_t         mem [BUFFER_DEPTH];
    logic [PW-1:0]  wptr, rptr;
    logic [CW-1:0]  count, count_nxt;
    occ_e           occ;
    logic           accept, rel;
    class_t         cls;
    entry_t         head;
    logic [31:0]    imm;

    assign in_ready  = (occ != OCC_FULL);
    assign out_valid = (occ != OCC_EMPTY);
    assign accept    = in_valid && in_ready && !flush;
    assign rel       = out_valid && out_ready && !flush;
    assign cls       = classify(in_instruction[6:0]);

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (accept && !rel)
            count_nxt = count + 1'b1;
        else if (!accept && rel)
            count_nxt = count - 1'b1;
    end

    // Occupancy state is registered alongside count so the handshake flags are flop-driven.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            occ   <= OCC_EMPTY;
        end else begin
            count <= count_nxt;
            if (count_nxt == '0)
                occ <= OCC_EMPTY;
            else if (count_nxt == CW'(BUFFER_DEPTH))
                occ <= OCC_FULL;
            else
                occ <= OCC_PARTIAL;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (accept) wptr <= wptr + 1'b1;
                if (rel)    rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr] <= '{instruction: in_instruction, pc: in_pc,
                           itype: cls.itype, illegal: cls.illegal};
    end

    assign head = mem[rptr];

    immediate_generator u_immgen (
        .instruction (head.instruction[31:7]),
        .itype       (head.itype),
        .immediate   (imm)
    );

    // Storage is not reset, so every output is gated by occupancy.
    assign out_instruction = out_valid ? head.instruction : '0;
    assign out_pc          = out_valid ? head.pc : '0;
    assign out_type        = out_valid ? head.itype : R_TYPE;
    assign out_illegal     = out_valid && head.illegal;
    assign out_immediate   = (out_valid && head.itype != R_TYPE) ? imm : '0;

`ifdef DECODE_STALL_COUNTER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (out_valid && !out_ready && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'd1;
    end
`endif

endmodule
